// File: rtl/blit_cmd_fifo.sv
// Purpose: CPU register front-end that assembles 96-bit blit commands and queues them for the sequencer.
// Latency: ack 1 cycle after request; CMD write to cmd_valid 2 cycles; next_cmd to new head 1 cycle.
// Backpressure: a CMD write into a full queue is not acked until the registered count shows a free slot.
//
// Ports:
//   clock, reset_n                    - core clock, async active-low reset
//   cpu_valid/cpu_write/cpu_addr/...  - CPU register port (0=ARG1 1=ARG2 2=CMD 3=STATUS), cpu_ack pulse
//   cmd, cmd_valid, next_cmd          - registered head entry and pop pulse to the sequencer
//   p5_idle                           - sequencer pipeline-drained flag, folded into STATUS busy
module blit_cmd_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cpu_valid,
   input  logic        cpu_write,
   input  logic [1:0]  cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   output logic [95:0] cmd,
   output logic        cmd_valid,
   input  logic        next_cmd,
   input  logic        p5_idle
);

   typedef struct packed {
      logic [31:0] arg2;
      logic [31:0] arg1;
      logic [23:0] pad;
      logic [7:0]  opcode;
   } blit_cmd_t;

   localparam logic [1:0]  REG_ARG1   = 2'd0;
   localparam logic [1:0]  REG_ARG2   = 2'd1;
   localparam logic [1:0]  REG_CMD    = 2'd2;
   localparam logic [1:0]  REG_STATUS = 2'd3;
   localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_CNT    = (AW+1)'(1);

   blit_cmd_t     mem [DEPTH];
   blit_cmd_t     head_q;
   blit_cmd_t     push_word;
   logic [31:0]   arg1_q, arg2_q;
   logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [AW:0]   count_q, count_nxt, remain;
   logic          accept, wr_cmd, full, flush, push, pop, bypass, head_vld_nxt;
   logic [31:0]   rd_mux;

   assign cmd = head_q;

   always_comb begin
      // The ack cycle blocks acceptance so a held cpu_valid is not taken twice.
      accept     = cpu_valid & ~cpu_ack;
      wr_cmd     = accept & cpu_write & (cpu_addr == REG_CMD);
      flush      = accept & cpu_write & (cpu_addr == REG_STATUS) & cpu_wdata[31];
      full       = (count_q == FULL_CNT);
      push       = wr_cmd & ~full & ~flush;
      pop        = next_cmd & cmd_valid;
      rd_ptr_nxt = rd_ptr + AW'(pop);
      count_nxt  = count_q + (AW+1)'(push) - (AW+1)'(pop);
      // Entries already in storage that remain after this cycle's pop.
      remain     = count_q - (AW+1)'(pop);
      // Popping the last stored entry while pushing: forward the pushed word so
      // cmd_valid never drops. A push into an empty queue is not forwarded,
      // which keeps the two-cycle write-to-valid latency.
      bypass       = push & pop & (count_q == ONE_CNT);
      head_vld_nxt = (remain != '0) | bypass;

      push_word        = '0;
      push_word.arg2   = arg2_q;
      push_word.arg1   = arg1_q;
      push_word.opcode = cpu_wdata[7:0];

      rd_mux = '0;
      case (cpu_addr)
         REG_ARG1: rd_mux = arg1_q;
         REG_ARG2: rd_mux = arg2_q;
         REG_CMD:  rd_mux = {24'h0, head_q.opcode};
         default: begin
            rd_mux[15:0] = 16'(FULL_CNT - count_q);
            rd_mux[16]   = (count_q == '0);
            rd_mux[17]   = cmd_valid | ~p5_idle;
         end
      endcase
   end

   // Storage has no reset so it maps onto distributed RAM.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= push_word;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         head_q    <= '0;
         cmd_valid <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         cmd_valid <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr    <= rd_ptr_nxt;
         count_q   <= count_nxt;
         cmd_valid <= head_vld_nxt;
         if (head_vld_nxt) begin
            head_q <= bypass ? push_word : mem[rd_ptr_nxt];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         arg1_q    <= '0;
         arg2_q    <= '0;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         cpu_ack <= accept & ~(wr_cmd & full);
         if (accept & cpu_write & (cpu_addr == REG_ARG1)) begin
            arg1_q <= cpu_wdata;
         end
         if (accept & cpu_write & (cpu_addr == REG_ARG2)) begin
            arg2_q <= cpu_wdata;
         end
         if (accept & ~cpu_write) begin
            cpu_rdata <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_blit_cmd_fifo.sv
module tb_blit_cmd_fifo;

   localparam logic [1:0] A_ARG1 = 2'd0;
   localparam logic [1:0] A_ARG2 = 2'd1;
   localparam logic [1:0] A_CMD  = 2'd2;
   localparam logic [1:0] A_STAT = 2'd3;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        cpu_valid, cpu_write;
   logic [1:0]  cpu_addr;
   logic [31:0] cpu_wdata, cpu_rdata;
   logic        cpu_ack;
   logic [95:0] cmd;
   logic        cmd_valid;
   logic        next_cmd, p5_idle;

   int checks   = 0;
   int failures = 0;

   logic [95:0] sb[$];
   logic [31:0] m_arg1 = '0;
   logic [31:0] m_arg2 = '0;

   blit_cmd_fifo #(.DEPTH(16)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .cpu_valid (cpu_valid),
      .cpu_write (cpu_write),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .next_cmd  (next_cmd),
      .p5_idle   (p5_idle)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic cpu_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic ok);
      @(negedge clock);
      cpu_valid = 1'b1;
      cpu_write = w;
      cpu_addr  = a;
      cpu_wdata = d;
      ok = 1'b0;
      rd = '0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clock);
         if (cpu_ack) begin
            ok = 1'b1;
            rd = cpu_rdata;
         end
      end
      cpu_valid = 1'b0;
      cpu_write = 1'b0;
   endtask

   task automatic reg_wr(input logic [1:0] a, input logic [31:0] d, input string tag);
      logic [31:0] rd;
      logic        ok;
      if (a == A_CMD) sb.push_back({m_arg2, m_arg1, 24'h0, d[7:0]});
      cpu_xfer(1'b1, a, d, rd, ok);
      check({tag, "_ack"}, 96'(ok), 96'(1));
      if (a == A_ARG1) m_arg1 = d;
      if (a == A_ARG2) m_arg2 = d;
   endtask

   task automatic reg_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] rd;
      logic        ok;
      cpu_xfer(1'b0, a, 32'h0, rd, ok);
      check({tag, "_ack"}, 96'(ok), 96'(1));
      check(tag, 96'(rd), 96'(exp));
   endtask

   // Samples at the current negedge, then pulses next_cmd for one cycle.
   task automatic pop_check(input string tag);
      logic        seen;
      logic [95:0] exp;
      seen = cmd_valid;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock);
         seen = cmd_valid;
      end
      check({tag, "_valid"}, 96'(seen), 96'(1));
      if (seen) begin
         exp = (sb.size() > 0) ? sb.pop_front() : 96'hx;
         check(tag, cmd, exp);
         next_cmd = 1'b1;
         @(negedge clock);
         next_cmd = 1'b0;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      logic acked;
      int   popped;
      int   budget;

      reset_n   = 1'b0;
      cpu_valid = 1'b0;
      cpu_write = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      next_cmd  = 1'b0;
      p5_idle   = 1'b1;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      check("rst_cmd_valid", 96'(cmd_valid), 96'(0));
      check("rst_cpu_ack",   96'(cpu_ack),   96'(0));
      check("rst_cmd",       cmd,            96'h0);
      check("rst_rdata",     96'(cpu_rdata), 96'(0));

      // Basic command assembly and write-to-valid latency.
      reg_wr(A_ARG1, 32'h0010_0020, "t1_arg1");
      reg_wr(A_ARG2, 32'h0040_0080, "t1_arg2");
      reg_wr(A_CMD,  32'h0000_0005, "t1_cmd");
      check("t1_valid_early", 96'(cmd_valid), 96'(0));
      @(negedge clock);
      check("t1_valid", 96'(cmd_valid), 96'(1));
      check("t1_cmd",   cmd, 96'h00400080_00100020_00000005);
      reg_rd(A_STAT, 32'h0002_000F, "t1_status");
      reg_rd(A_CMD,  32'h0000_0005, "t1_cmd_rd");
      pop_check("t1_pop");
      check("t1_empty_after_pop", 96'(cmd_valid), 96'(0));

      // Fill to capacity, stall the 17th, release it with one pop.
      for (int i = 1; i <= 16; i++) reg_wr(A_CMD, 32'(i), "t2_fill");
      reg_rd(A_STAT, 32'h0002_0000, "t2_status_full");
      sb.push_back({m_arg2, m_arg1, 24'h0, 8'd17});
      @(negedge clock);
      cpu_valid = 1'b1;
      cpu_write = 1'b1;
      cpu_addr  = A_CMD;
      cpu_wdata = 32'd17;
      acked = 1'b0;
      repeat (5) begin
         @(negedge clock);
         acked = acked | cpu_ack;
      end
      check("t2_full_hold", 96'(acked), 96'(0));
      pop_check("t2_pop_first");
      ok = 1'b0;
      for (int i = 0; i < 2 && !ok; i++) begin
         @(negedge clock);
         if (cpu_ack) ok = 1'b1;
      end
      cpu_valid = 1'b0;
      cpu_write = 1'b0;
      check("t2_release_ack", 96'(ok), 96'(1));
      for (int i = 2; i <= 17; i++) pop_check("t2_pop");
      check("t2_drained", 96'(cmd_valid), 96'(0));

      // Continuous pushes against a pop every second cycle, 40 commands.
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               if (i % 8 == 0) reg_wr(A_ARG1, 32'hA000_0000 + 32'(i), "t3_arg1");
               if (i % 13 == 0) reg_wr(A_ARG2, 32'hB000_0000 + 32'(i), "t3_arg2");
               reg_wr(A_CMD, 32'(8'h40 + i), "t3_cmd");
            end
         end
         begin
            popped = 0;
            budget = 3000;
            while (popped < 40 && budget > 0) begin
               if (cmd_valid) begin
                  check("t3_pop", cmd, (sb.size() > 0) ? sb.pop_front() : 96'hx);
                  next_cmd = 1'b1;
                  @(negedge clock);
                  next_cmd = 1'b0;
                  popped++;
               end
               @(negedge clock);
               budget--;
            end
            check("t3_pop_count", 96'(popped), 96'(40));
         end
      join
      @(negedge clock);
      check("t3_sb_empty",  96'(sb.size()), 96'(0));
      check("t3_drained",   96'(cmd_valid),  96'(0));

      // next_cmd on an empty queue is ignored.
      next_cmd = 1'b1;
      @(negedge clock);
      next_cmd = 1'b0;
      @(negedge clock);
      check("t4_empty_valid", 96'(cmd_valid), 96'(0));
      reg_rd(A_STAT, 32'h0001_0010, "t4_status");
      reg_wr(A_ARG1, 32'h1234_5678, "t4_arg1");
      reg_wr(A_CMD,  32'h0000_0042, "t4_cmd");
      pop_check("t4_pop");

      // Flush with five queued commands.
      for (int i = 0; i < 5; i++) reg_wr(A_CMD, 32'(8'h60 + i), "t5_cmd");
      @(negedge clock);
      check("t5_valid_before", 96'(cmd_valid), 96'(1));
      reg_wr(A_STAT, 32'h8000_0000, "t5_flush");
      sb.delete();
      check("t5_valid_after", 96'(cmd_valid), 96'(0));
      reg_rd(A_STAT, 32'h0001_0010, "t5_status");
      reg_rd(A_ARG1, m_arg1, "t5_arg1_kept");
      reg_wr(A_STAT, 32'h0000_0000, "t5_status_nop");
      check("t5_nop_valid", 96'(cmd_valid), 96'(0));

      // Busy follows p5_idle when empty.
      p5_idle = 1'b0;
      reg_rd(A_STAT, 32'h0003_0010, "t6_busy");
      p5_idle = 1'b1;
      reg_rd(A_STAT, 32'h0001_0010, "t6_idle");

      // Reset in the middle of a CMD write.
      reg_wr(A_CMD, 32'h0000_0077, "t6_cmd");
      @(negedge clock);
      check("t6_valid_pre", 96'(cmd_valid), 96'(1));
      cpu_valid = 1'b1;
      cpu_write = 1'b1;
      cpu_addr  = A_CMD;
      cpu_wdata = 32'h0000_0099;
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_valid", 96'(cmd_valid), 96'(0));
      acked = cpu_ack;
      repeat (2) begin
         @(negedge clock);
         acked = acked | cpu_ack;
      end
      cpu_valid = 1'b0;
      cpu_write = 1'b0;
      reset_n   = 1'b1;
      sb.delete();
      m_arg1 = '0;
      m_arg2 = '0;
      check("t6_rst_noack", 96'(acked), 96'(0));
      repeat (2) @(negedge clock);
      check("t6_post_valid", 96'(cmd_valid), 96'(0));
      reg_rd(A_ARG1, 32'h0, "t6_arg1_reset");
      reg_rd(A_STAT, 32'h0001_0010, "t6_status_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/blit_cmd_fifo.md
Name: blit_cmd_fifo

Overview:
- CPU-facing command queue directly upstream of the blitter command sequencer.
- Collects CPU register writes into 96-bit blit commands: {arg2, arg1, 24'b0, opcode}.
- Buffers commands in a FIFO and presents the head entry to the sequencer via cmd/cmd_valid/next_cmd.
- Reports queue occupancy and blitter busy status back to the CPU.

Parameters:
- DEPTH, 16, number of 96-bit command entries; power of two, 2..256.
- AW, $clog2(DEPTH), pointer width.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_valid  in  1  CPU request strobe; held until cpu_ack.
- cpu_write  in  1  1=write, 0=read.
- cpu_addr  in  2  word register index: 0=ARG1, 1=ARG2, 2=CMD, 3=STATUS.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle request completion pulse.
- cmd  out  96  head entry; [7:0]=opcode, [31:8]=0, [63:32]=arg1, [95:64]=arg2.
- cmd_valid  out  1  FIFO non-empty.
- next_cmd  in  1  one-cycle pop pulse from the sequencer.
- p5_idle  in  1  blitter pipeline-drained flag from the sequencer.

Behaviour:
- Reset (async assert, sync release): pointers=0, count=0, ARG1/ARG2 staging=0, cmd=0, cmd_valid=0, cpu_ack=0, cpu_rdata=0.
- ARG1/ARG2 write: updates the staging register; cpu_ack the next cycle; no push.
- CMD write, count<DEPTH: pushes {ARG2, ARG1, 24'b0, wdata[7:0]}; cpu_ack the next cycle. Staging registers keep their values, so repeated commands can reuse the arguments.
- CMD write, count==DEPTH: cpu_ack held low (backpressure) until a slot frees. Full is evaluated on the registered count only; a pop in the same cycle does not admit the push until the following cycle.
- STATUS write, wdata[31]=1: flush. Pointers, count, cmd_valid=0 on the next edge. A push that collides with a flush is discarded. Staging registers are unaffected.
- STATUS write, wdata[31]=0: no effect besides ack.
- Reads are acked the cycle after cpu_valid.
  - ARG1/ARG2 return staging values.
  - CMD returns {24'b0, head opcode}.
  - STATUS returns:
    - [15:0]: free slots (DEPTH-count).
    - [16]: empty.
    - [17]: busy = cmd_valid | !p5_idle.
    - [31:18]: 0.
- cpu_ack is never asserted two cycles in a row. A new request is accepted only the cycle after an ack.
- Output is a registered head. After a push into an empty FIFO, cmd and cmd_valid=1 appear the cycle after the push edge, giving 2-cycle write-to-valid latency.
- next_cmd with cmd_valid=1 pops the entry. The new head (or cmd_valid=0) is visible the cycle after the pulse.
  - The sequencer waits one cycle after next_cmd before sampling cmd, so this latency is mandatory and must not be lengthened.
- next_cmd while empty: ignored; pointers unchanged; no error.
- Simultaneous push and pop, count between 1 and DEPTH-1: count unchanged, both pointers advance. Ordering is strictly FIFO.
- Push while count==1 and popping the same cycle: the new entry becomes head one cycle after the pop and cmd_valid stays 1.
- Pointers wrap modulo DEPTH. count is AW+1 bits wide.
- Storage is inferable as distributed RAM: one write port plus a registered read of the head.
- reset_n asserted mid-transfer: in-flight CPU access is dropped (no ack) and the FIFO empties.

Test Plan:
- Reset, then write ARG1=0x00100020, ARG2=0x00400080, CMD=0x05 -> two cycles after the CMD write edge, cmd_valid=1 and cmd=96'h00400080_00100020_00000005. STATUS reads free=15, empty=0, busy=1.
- Push 16 commands (opcodes 1..16), then a 17th -> 17th cpu_ack held low. Pulse next_cmd once -> 17th acked within 2 cycles. Pops return opcodes 1..17 in order.
- Hold next_cmd every 2nd cycle while pushing continuously -> no loss or duplication. Count never exceeds DEPTH. Wrap past 16 entries verified over 40 commands.
- Pulse next_cmd with the FIFO empty -> no pointer change. The next push appears with correct contents.
- Queue 5 commands, STATUS write 0x80000000 -> cmd_valid=0 next cycle, STATUS free=16, empty=1. The ARG1 readback is unchanged.
- With the FIFO empty and p5_idle=0 -> STATUS[17]=1. Set p5_idle=1 -> STATUS[17]=0. Assert reset_n=0 mid CMD write -> no ack, cmd_valid=0 immediately.
